// File: rtl/cache_if.sv
// CPU request/response and RAM port bundle for the direct-mapped cache.
// The controller takes the slave view; the CPU/RAM side takes the master view.
interface cache_if #(
   parameter int ADDLENGTH  = 16,
   parameter int DATALENGTH = 32
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDLENGTH-1:0]  cpu_addr;
   logic [DATALENGTH-1:0] cpu_wdata;
   logic [DATALENGTH-1:0] cpu_rdata;
   logic                  cpu_ready;
   logic                  cpu_hit;
   logic [ADDLENGTH-1:0]  mem_addr;
   logic [DATALENGTH-1:0] mem_datain;
   logic [DATALENGTH-1:0] mem_dataout;
   logic                  mem_RE;
   logic                  mem_WE;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dataout,
      output cpu_rdata, cpu_ready, cpu_hit,
      output mem_addr, mem_datain, mem_RE, mem_WE
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_dataout,
      input  cpu_rdata, cpu_ready, cpu_hit,
      input  mem_addr, mem_datain, mem_RE, mem_WE
   );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller
// with one-word lines in front of a single-port synchronous RAM.
module cache_controller #(
   parameter int ADDLENGTH  = 16,
   parameter int DATALENGTH = 32,
   parameter int INDEXBITS  = 3
) (
   input  logic    clk,
   input  logic    rst,
   cache_if.slave  bus
);
   localparam int LINES   = 1 << INDEXBITS;
   localparam int TAGBITS = ADDLENGTH - INDEXBITS;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_MEM
   } state_t;

   state_t state, state_nx;

   logic [ADDLENGTH-1:0]  addr_q;
   logic [DATALENGTH-1:0] wdata_q;
   logic                  we_q;
   logic                  hit_q;
   logic [DATALENGTH-1:0] rdata_q;
   logic                  ready_q;
   logic                  chit_q;

   logic [LINES-1:0]      valid_q;
   logic [TAGBITS-1:0]    tag_q  [LINES];
   logic [DATALENGTH-1:0] data_q [LINES];

   logic [INDEXBITS-1:0]  idx;
   logic [TAGBITS-1:0]    tag;
   logic                  hit;

   assign idx = addr_q[INDEXBITS-1:0];
   assign tag = addr_q[ADDLENGTH-1:INDEXBITS];
   assign hit = valid_q[idx] && (tag_q[idx] == tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.cpu_req) state_nx = LOOKUP;
         LOOKUP: begin
            if (we_q)     state_nx = WR_MEM;
            else if (hit) state_nx = IDLE;
            else          state_nx = RD_REQ;
         end
         RD_REQ:  state_nx = RD_WAIT;
         RD_WAIT: state_nx = IDLE;
         WR_MEM:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         hit_q   <= 1'b0;
         valid_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         chit_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         chit_q  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.cpu_req) begin
                  addr_q  <= bus.cpu_addr;
                  wdata_q <= bus.cpu_wdata;
                  we_q    <= bus.cpu_we;
               end
            end
            LOOKUP: begin
               hit_q <= hit;
               if (!we_q && hit) begin
                  rdata_q <= data_q[idx];
                  ready_q <= 1'b1;
                  chit_q  <= 1'b1;
               end
            end
            RD_WAIT: begin
               valid_q[idx] <= 1'b1;
               rdata_q      <= bus.mem_dataout;
               ready_q      <= 1'b1;
            end
            WR_MEM: begin
               ready_q <= 1'b1;
               chit_q  <= hit_q;
            end
            default: ;
         endcase
      end
   end

   // Tags and data need no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (state == RD_WAIT) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= bus.mem_dataout;
      end else if (state == WR_MEM && hit_q) begin
         data_q[idx] <= wdata_q;
      end
   end

   assign bus.mem_addr   = addr_q;
   assign bus.mem_datain = wdata_q;
   assign bus.mem_RE     = (state == RD_REQ);
   assign bus.mem_WE     = (state == WR_MEM);
   assign bus.cpu_rdata  = rdata_q;
   assign bus.cpu_ready  = ready_q;
   assign bus.cpu_hit    = chit_q;
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed plan plus random traffic
// checked every cycle against a behavioural cache/RAM model.
module tb_cache_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;

   cache_if #(.ADDLENGTH(16), .DATALENGTH(32)) bus ();

   cache_controller #(
      .ADDLENGTH(16), .DATALENGTH(32), .INDEXBITS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [65536];

   always @(posedge clk) begin
      if (bus.mem_WE) ram[bus.mem_addr] <= bus.mem_datain;
      if (bus.mem_RE) bus.mem_dataout <= ram[bus.mem_addr];
   end

   // Behavioural cache model: 8 one-word lines.
   bit          mv [8];
   logic [12:0] mt [8];
   logic [31:0] md [8];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   int          re_cyc  = -1;
   int          we_cyc  = -1;
   int          rdy_cyc = -1;
   bit          p_read;
   bit          p_hit;
   logic [15:0] p_addr;
   logic [31:0] p_wdata;
   logic [31:0] p_rdata;
   logic [31:0] hold_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h want %h",
                  name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      chk("mem_RE", 32'(bus.mem_RE), 32'(cyc == re_cyc));
      chk("mem_WE", 32'(bus.mem_WE), 32'(cyc == we_cyc));
      chk("cpu_ready", 32'(bus.cpu_ready), 32'(cyc == rdy_cyc));
      if (cyc == rdy_cyc) begin
         chk("cpu_hit", 32'(bus.cpu_hit), 32'(p_hit));
         if (p_read) hold_rdata = p_rdata;
      end
      chk("cpu_rdata", bus.cpu_rdata, hold_rdata);
      if (cyc == re_cyc || cyc == we_cyc)
         chk("mem_addr", 32'(bus.mem_addr), 32'(p_addr));
      if (cyc == we_cyc)
         chk("mem_datain", bus.mem_datain, p_wdata);
   end

   task automatic req(input bit we, input logic [15:0] a,
                      input logic [31:0] d);
      int          idx;
      logic [12:0] tg;
      bit          h;
      int          c;
      idx = int'(a[2:0]);
      tg  = a[15:3];
      h   = mv[idx] && (mt[idx] == tg);
      c   = cyc;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      p_read  = !we;
      p_hit   = h;
      p_addr  = a;
      p_wdata = d;
      re_cyc  = -1;
      we_cyc  = -1;
      if (!we && h) begin
         rdy_cyc = c + 2;
         p_rdata = md[idx];
      end else if (!we) begin
         re_cyc  = c + 2;
         rdy_cyc = c + 4;
         p_rdata = ram[a];
         mv[idx] = 1'b1;
         mt[idx] = tg;
         md[idx] = ram[a];
      end else begin
         we_cyc  = c + 2;
         rdy_cyc = c + 3;
         if (h) md[idx] = d;
      end
      @(negedge clk);
      for (int k = 0; k < 8 && cyc < rdy_cyc; k++) begin
         // Requests outside IDLE must be ignored.
         bus.cpu_req   = 1'($urandom_range(0, 1));
         bus.cpu_we    = 1'($urandom_range(0, 1));
         bus.cpu_addr  = 16'($urandom);
         bus.cpu_wdata = $urandom;
         @(negedge clk);
      end
      bus.cpu_req = 1'b0;
      chk("done", 32'(cyc), 32'(rdy_cyc));
   endtask

   initial begin
      bus.cpu_req     = 1'b0;
      bus.cpu_we      = 1'b0;
      bus.cpu_addr    = '0;
      bus.cpu_wdata   = '0;
      bus.mem_dataout = '0;
      for (int i = 0; i < 65536; i++) ram[i] = $urandom;
      for (int i = 0; i < 8; i++) mv[i] = 1'b0;
      ram[3] = 32'hA5A5A5A5;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      req(1'b0, 16'h0003, '0);
      chk("t1 rdata", bus.cpu_rdata, 32'hA5A5A5A5);
      chk("t1 hit", 32'(bus.cpu_hit), 32'd0);
      req(1'b0, 16'h0003, '0);
      chk("t2 hit", 32'(bus.cpu_hit), 32'd1);
      req(1'b1, 16'h0003, 32'h12345678);
      chk("t3 hit", 32'(bus.cpu_hit), 32'd1);
      chk("t3 ram", ram[3], 32'h12345678);
      req(1'b0, 16'h0003, '0);
      chk("t3 rd", bus.cpu_rdata, 32'h12345678);
      req(1'b1, 16'h000B, 32'hDEADBEEF);
      chk("t4 hit", 32'(bus.cpu_hit), 32'd0);
      chk("t4 ram", ram[11], 32'hDEADBEEF);
      req(1'b0, 16'h0003, '0);
      chk("t4 rd hit", 32'(bus.cpu_hit), 32'd1);
      chk("t4 rd", bus.cpu_rdata, 32'h12345678);
      req(1'b0, 16'h000B, '0);
      chk("t5 hit", 32'(bus.cpu_hit), 32'd0);
      chk("t5 rd", bus.cpu_rdata, 32'hDEADBEEF);
      req(1'b0, 16'h0003, '0);
      chk("t5 evict hit", 32'(bus.cpu_hit), 32'd0);
      chk("t5 evict rd", bus.cpu_rdata, 32'h12345678);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clk);
         req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
             $urandom);
      end

      // Reset during RD_WAIT of a read miss.
      begin
         int c;
         c = cyc;
         bus.cpu_req  = 1'b1;
         bus.cpu_we   = 1'b0;
         bus.cpu_addr = 16'h1005;
         p_addr  = 16'h1005;
         p_read  = 1'b1;
         re_cyc  = c + 2;
         we_cyc  = -1;
         rdy_cyc = c + 4;
         @(negedge clk);
         bus.cpu_req = 1'b0;
         while (cyc < c + 3) @(negedge clk);
         rst        = 1'b1;
         re_cyc     = -1;
         rdy_cyc    = -1;
         hold_rdata = '0;
         for (int i = 0; i < 8; i++) mv[i] = 1'b0;
         #1;
         chk("rst ready", 32'(bus.cpu_ready), 32'd0);
         chk("rst rdata", bus.cpu_rdata, 32'd0);
         chk("rst addr", 32'(bus.mem_addr), 32'd0);
         chk("rst datain", bus.mem_datain, 32'd0);
         chk("rst RE", 32'(bus.mem_RE), 32'd0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
      end
      req(1'b0, 16'h1005, '0);
      chk("post rst hit", 32'(bus.cpu_hit), 32'd0);
      chk("post rst rd", bus.cpu_rdata, ram[16'h1005]);

      for (int n = 0; n < 60; n++)
         req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
             $urandom);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate cache controller. It takes single-word read/write requests from the CPU and acts as the requesting side of the single-port synchronous RAM interface (addr, datain, dataout, RE, WE). That RAM returns read data one clock after RE is sampled. The controller serves read hits from an internal line array and fetches read misses from RAM. Every write goes through to RAM.

## Interface
- ADDLENGTH, 16, width of CPU and RAM word address
- DATALENGTH, 32, width of data word
- INDEXBITS, 3, index width; 2**INDEXBITS lines of one word each; tag width = ADDLENGTH-INDEXBITS
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDLENGTH  word address; sampled with cpu_req
- cpu_wdata  in  DATALENGTH  write data; sampled with cpu_req
- cpu_rdata  out  DATALENGTH  read result; registered; updated only on read completion; holds otherwise
- cpu_ready  out  1  one-cycle completion pulse; registered
- cpu_hit  out  1  valid with cpu_ready: 1 = lookup hit; 0 otherwise
- mem_addr  out  ADDLENGTH  RAM address; equals latched request address
- mem_datain  out  DATALENGTH  RAM write data; equals latched write data
- mem_dataout  in  DATALENGTH  RAM read data; valid in the cycle after mem_RE is sampled
- mem_RE  out  1  RAM read enable; high only in RD_REQ
- mem_WE  out  1  RAM write enable; high only in WR_MEM

## Operation
- Per line: valid bit, tag, data word. index = addr[INDEXBITS-1:0]; tag = addr[ADDLENGTH-1:INDEXBITS].
- States:
  - IDLE: if cpu_req, latch addr, we, wdata and go to LOOKUP.
  - LOOKUP: hit = valid[index] and tag match.
    - Read hit: cpu_rdata <= line data, cpu_ready <= 1, cpu_hit <= 1, go to IDLE.
    - Read miss: go to RD_REQ.
    - Write, hit or miss: go to WR_MEM and record the hit result.
  - RD_REQ: mem_RE = 1; go to RD_WAIT.
  - RD_WAIT: the line takes valid = 1, the tag, and mem_dataout. cpu_rdata <= mem_dataout, cpu_ready <= 1, cpu_hit <= 0. Go to IDLE.
  - WR_MEM: mem_WE = 1.
    - Recorded hit: line data <= latched wdata.
    - Miss: line untouched (no allocate), valid and tag unchanged.
    - cpu_ready <= 1, cpu_hit <= recorded hit, go to IDLE.
- mem_RE and mem_WE are never high together. Each is high for exactly one cycle per access.
- cpu_req outside IDLE is ignored; no queueing.
- A cpu_req in the same cycle as cpu_ready is in IDLE and is accepted, so back-to-back requests are legal.
- Address conflict: a read miss evicts the old line unconditionally. No writeback is needed because the cache is write-through.

## Timing
- Request sampled at edge E0. cpu_ready is high in the cycle after:
  - read hit: E1 (2-cycle latency)
  - write: E2
  - read miss: E3
- Read miss: mem_RE is high in the cycle between E1 and E2, and the RAM samples it at E2. mem_dataout is captured at E3.
- Write: mem_WE is high between E1 and E2, and the RAM writes at E2.
- Reset values:
  - state IDLE; all valid bits 0
  - cpu_rdata 0, cpu_ready 0, cpu_hit 0
  - mem_RE 0, mem_WE 0, mem_addr 0, mem_datain 0
  - tags and line data are don't-care
- Reset mid-operation aborts the access: no cpu_ready, no line update. If the RAM already sampled mem_WE, that write is not undone.
- mem_RE and mem_WE are decoded from state only; they never depend combinationally on CPU inputs.

## Test plan
- Reset, then read addr 0x0003 with RAM[3]=0xA5A5A5A5 -> one mem_RE pulse; cpu_ready 4 cycles after req with cpu_rdata=0xA5A5A5A5, cpu_hit=0.
- Read 0x0003 again -> no mem_RE; cpu_ready 2 cycles after req with cpu_rdata=0xA5A5A5A5, cpu_hit=1.
- Write 0x0003 data 0x12345678 (hit) -> one mem_WE pulse with mem_addr=3, mem_datain=0x12345678; cpu_hit=1. A following read of 0x0003 hits and returns 0x12345678, and RAM[3]=0x12345678.
- Write 0x000B data 0xDEADBEEF (miss, same index as 0x0003) -> RAM[11] updated, cpu_hit=0. A following read of 0x0003 still hits with 0x12345678.
- Read 0x000B -> miss with mem_RE, returns 0xDEADBEEF; the line is evicted, so a next read of 0x0003 misses (cpu_hit=0) and returns 0x12345678.
- Assert rst during RD_WAIT of a read miss -> cpu_ready never pulses, outputs go to reset values immediately; a subsequent read of the same address misses.
